// File: rtl/aes_link_rx_pkg.sv
// rtl/aes_link_rx_pkg.sv - shared constants, FSM encoding and timing derivations for the AES link receiver
package aes_link_rx_pkg;

    localparam int AES_LINK_BYTES = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } rx_state_e;

    function automatic int byte_period(input int clk_freq, input int tx_freq);
        return clk_freq / tx_freq;
    endfunction

    function automatic int timeout_cyc(input int timeout_bytes, input int period);
        return timeout_bytes * period;
    endfunction

endpackage

// File: rtl/aes_link_timeout.sv
// rtl/aes_link_timeout.sv - idle counter that pulses when a receive stalls for TIMEOUT_CYC cycles
module aes_link_timeout #(
    parameter int TIMEOUT_CYC = 28
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart_i,
    input  logic enable_i,
    output logic timeout_o
);

    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          at_last;

    assign at_last   = (cnt_q == LAST);
    // A restart in the terminal cycle means a byte arrived just in time.
    assign timeout_o = enable_i & ~restart_i & at_last;

    always_comb begin
        cnt_d = cnt_q;
        if (!enable_i || restart_i || at_last) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/aes_link_rx.sv
// rtl/aes_link_rx.sv - captures strobed link bytes, assembles 128-bit blocks and presents them on valid/ready
import aes_link_rx_pkg::*;

module aes_link_rx #(
    parameter int CLK_FREQ      = 50_000_000,
    parameter int AES_TX_FREQ   = 7_000_000,
    parameter int TIMEOUT_BYTES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [8:0]   aes_rx,
    output logic [127:0] block,
    output logic         block_valid,
    input  logic         block_ready,
    output logic [31:0]  block_cnt,
    output logic         overrun,
    output logic         timeout_err,
    input  logic         clr_status
);

    localparam int BYTE_PERIOD = byte_period(CLK_FREQ, AES_TX_FREQ);
    localparam int TIMEOUT_CYC = timeout_cyc(TIMEOUT_BYTES, BYTE_PERIOD);
    localparam logic [3:0] LAST_BYTE = 4'(AES_LINK_BYTES - 1);

    logic [8:0]   aes_q;
    logic         prev8_q;
    logic         take;
    logic         tmo;

    rx_state_e    state_q, state_d;
    logic [3:0]   byte_cnt_q, byte_cnt_d;
    logic [127:0] shift_q, shift_d;
    logic         done_d, done_q;
    logic         cmpl_q;
    logic         tmo_set;

    logic [127:0] block_q, block_d;
    logic         block_valid_q, block_valid_d;
    logic [31:0]  block_cnt_q, block_cnt_d;
    logic         overrun_q, overrun_d;
    logic         timeout_err_q, timeout_err_d;
    logic         out_free;
    logic         write;
    logic         drop;

    assign take = aes_q[8] & ~prev8_q;

    aes_link_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart_i (take),
        .enable_i  (state_q == ST_RECV),
        .timeout_o (tmo)
    );

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        done_d     = 1'b0;
        tmo_set    = 1'b0;
        if (take) begin
            shift_d    = {shift_q[119:0], aes_q[7:0]};
            byte_cnt_d = byte_cnt_q + 4'd1;
        end
        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    state_d = ST_RECV;
                end
            end
            ST_RECV: begin
                // byte_cnt wraps to zero naturally on the sixteenth byte.
                if (take && (byte_cnt_q == LAST_BYTE)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (tmo) begin
                    state_d    = ST_IDLE;
                    byte_cnt_d = 4'd0;
                    tmo_set    = 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                byte_cnt_d = 4'd0;
            end
        endcase
    end

    // shift_q holds the finished block until the write edge; the next byte cannot land earlier.
    assign out_free = ~block_valid_q | block_ready;
    assign write    = cmpl_q & out_free;
    assign drop     = cmpl_q & ~out_free;

    always_comb begin
        block_d       = block_q;
        block_valid_d = block_valid_q;
        block_cnt_d   = block_cnt_q;
        overrun_d     = overrun_q;
        timeout_err_d = timeout_err_q;
        if (write) begin
            block_d       = shift_q;
            block_valid_d = 1'b1;
            block_cnt_d   = block_cnt_q + 32'd1;
        end else if (block_valid_q && block_ready) begin
            block_valid_d = 1'b0;
        end
        if (clr_status) begin
            overrun_d     = 1'b0;
            timeout_err_d = 1'b0;
        end else begin
            if (drop) begin
                overrun_d = 1'b1;
            end
            if (tmo_set) begin
                timeout_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aes_q         <= '0;
            prev8_q       <= 1'b0;
            state_q       <= ST_IDLE;
            byte_cnt_q    <= '0;
            shift_q       <= '0;
            done_q        <= 1'b0;
            cmpl_q        <= 1'b0;
            block_q       <= '0;
            block_valid_q <= 1'b0;
            block_cnt_q   <= '0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            aes_q         <= aes_rx;
            prev8_q       <= aes_q[8];
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            shift_q       <= shift_d;
            done_q        <= done_d;
            cmpl_q        <= done_q;
            block_q       <= block_d;
            block_valid_q <= block_valid_d;
            block_cnt_q   <= block_cnt_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign block       = block_q;
    assign block_valid = block_valid_q;
    assign block_cnt   = block_cnt_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_aes_link_rx.sv
// tb/tb_aes_link_rx.sv - randomized and directed bench for aes_link_rx against a timeline reference model
module tb_aes_link_rx;

    localparam int TIMEOUT_CYC = 4 * (50_000_000 / 7_000_000);

    logic         clk = 1'b0;
    logic         rst_n;
    logic [8:0]   aes_rx;
    logic [127:0] block;
    logic         block_valid;
    logic         block_ready;
    logic [31:0]  block_cnt;
    logic         overrun;
    logic         timeout_err;
    logic         clr_status;

    always #5 clk = ~clk;

    aes_link_rx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .aes_rx      (aes_rx),
        .block       (block),
        .block_valid (block_valid),
        .block_ready (block_ready),
        .block_cnt   (block_cnt),
        .overrun     (overrun),
        .timeout_err (timeout_err),
        .clr_status  (clr_status)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    bit rand_mode = 1'b0;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference: every byte strobe rising edge lands one edge after it is sampled,
    // a full block reaches the output two edges after its last byte lands.
    typedef struct {
        int           at;
        logic [127:0] data;
    } wr_t;

    wr_t          m_wrq[$];
    logic [127:0] m_block, m_part;
    logic [31:0]  m_cnt;
    bit           m_valid, m_ovr, m_tmo;
    int           m_n, m_last, cyc;
    bit           m_recv, m_prev_s, m_pend;
    logic [7:0]   m_pend_b;

    always @(posedge clk) begin : model
        bit         take;
        logic [7:0] b;
        bit         set_ovr, set_tmo;
        cyc++;
        if (!rst_n) begin
            m_wrq.delete();
            m_block = '0; m_part = '0; m_cnt = '0;
            m_valid = 0; m_ovr = 0; m_tmo = 0;
            m_n = 0; m_recv = 0; m_prev_s = 0; m_pend = 0; m_pend_b = '0;
        end else begin
            take = m_pend;
            b = m_pend_b;
            m_pend = aes_rx[8] & ~m_prev_s;
            m_pend_b = aes_rx[7:0];
            m_prev_s = aes_rx[8];
            set_ovr = 0;
            set_tmo = 0;
            if (take) begin
                m_part = {m_part[119:0], b};
                m_n++;
                m_last = cyc;
                m_recv = 1;
                if (m_n == 16) begin
                    m_wrq.push_back('{cyc + 2, m_part});
                    m_n = 0;
                    m_recv = 0;
                end
            end else if (m_recv && (cyc - m_last == TIMEOUT_CYC)) begin
                set_tmo = 1;
                m_recv = 0;
                m_n = 0;
            end
            if (m_wrq.size() > 0 && m_wrq[0].at == cyc) begin
                if (!m_valid || block_ready) begin
                    m_block = m_wrq[0].data;
                    m_valid = 1;
                    m_cnt++;
                end else begin
                    set_ovr = 1;
                end
                void'(m_wrq.pop_front());
            end else if (m_valid && block_ready) begin
                m_valid = 0;
            end
            if (clr_status) begin
                m_ovr = 0;
                m_tmo = 0;
            end else begin
                if (set_ovr) m_ovr = 1;
                if (set_tmo) m_tmo = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("block", block, m_block);
            chk("block_valid", block_valid, m_valid);
            chk("block_cnt", block_cnt, m_cnt);
            chk("overrun", overrun, m_ovr);
            chk("timeout_err", timeout_err, m_tmo);
        end
    end

    int   rises = 0;
    logic prev_v = 1'b0;
    always @(negedge clk) begin
        if (block_valid === 1'b1 && prev_v !== 1'b1) rises++;
        prev_v = block_valid;
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_mode) begin
            block_ready = ($urandom_range(0, 3) != 0);
            clr_status  = ($urandom_range(0, 63) == 0);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        aes_rx = '0;
        step();
        rst_n = 1'b1;
        rises = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
        aes_rx = {1'b1, b};
        repeat (hold) step();
        aes_rx = {1'b0, 8'($urandom)};
        repeat (gap) step();
    endtask

    task automatic send_block(input logic [127:0] data, input int hold, input int period);
        for (int i = 0; i < 16; i++) send_byte(data[127 - 8*i -: 8], hold, period - hold);
    endtask

    localparam logic [127:0] SEQ0 = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] SEQA = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;
    localparam logic [127:0] SEQ4 = 128'h404142434445464748494A4B4C4D4E4F;
    localparam logic [127:0] SEQC = 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF;
    localparam logic [127:0] ALL11 = {16{8'h11}};
    localparam logic [127:0] ALL22 = {16{8'h22}};

    initial begin
        logic [127:0] seq;
        rst_n = 1'b0;
        aes_rx = '0;
        block_ready = 1'b1;
        clr_status = 1'b0;
        repeat (3) step();
        do_reset();
        chk_en = 1'b1;
        chk("reset_block", block, 128'h0);
        chk("reset_valid", block_valid, 1'b0);
        chk("reset_cnt", block_cnt, 32'd0);

        // 1-cycle strobes, plus latency of the final byte
        seq = SEQ0;
        for (int i = 0; i < 15; i++) send_byte(seq[127 - 8*i -: 8], 1, 6);
        aes_rx = {1'b1, 8'h0F};
        step();
        chk("lat_e0", block_valid, 1'b0);
        aes_rx = '0;
        step();
        chk("lat_e1", block_valid, 1'b0);
        step();
        chk("lat_e2", block_valid, 1'b0);
        step();
        chk("lat_e3", block_valid, 1'b1);
        repeat (10) step();
        chk("t1_block", block, SEQ0);
        chk("t1_cnt", block_cnt, 32'd1);
        chk("t1_pulses", rises, 1);

        // strobe held 5 of 7 cycles
        do_reset();
        send_block(SEQ0, 5, 7);
        repeat (10) step();
        chk("t2_block", block, SEQ0);
        chk("t2_cnt", block_cnt, 32'd1);
        chk("t2_pulses", rises, 1);

        // partial block then idle timeout
        do_reset();
        for (int i = 0; i < 5; i++) send_byte(8'h55, 1, 6);
        repeat (40) step();
        chk("t3_tmo_early", timeout_err, 1'b1);
        send_block(SEQA, 1, 7);
        repeat (10) step();
        chk("t3_block", block, SEQA);
        chk("t3_cnt", block_cnt, 32'd1);
        chk("t3_tmo", timeout_err, 1'b1);

        // overrun with consumer stalled
        do_reset();
        block_ready = 1'b0;
        send_block(ALL11, 1, 7);
        repeat (10) step();
        send_block(ALL22, 1, 7);
        repeat (10) step();
        chk("t4_block", block, ALL11);
        chk("t4_ovr", overrun, 1'b1);
        chk("t4_cnt", block_cnt, 32'd1);
        block_ready = 1'b1;
        step();
        block_ready = 1'b0;
        step();
        chk("t4_valid_after", block_valid, 1'b0);
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        chk("t4_clr", overrun, 1'b0);

        // new block written in the same edge the old one is accepted
        do_reset();
        block_ready = 1'b0;
        send_block(ALL11, 1, 7);
        repeat (10) step();
        seq = SEQ4;
        for (int i = 0; i < 15; i++) send_byte(seq[127 - 8*i -: 8], 1, 6);
        aes_rx = {1'b1, 8'h4F};
        step();
        aes_rx = '0;
        step();
        step();
        block_ready = 1'b1;
        step();
        block_ready = 1'b0;
        chk("t5_valid", block_valid, 1'b1);
        chk("t5_block", block, SEQ4);
        chk("t5_ovr", overrun, 1'b0);
        chk("t5_cnt", block_cnt, 32'd2);
        step();
        chk("t5_valid_hold", block_valid, 1'b1);

        // reset mid-block
        for (int i = 0; i < 8; i++) send_byte(8'hEE, 1, 6);
        rst_n = 1'b0;
        step();
        chk("t6_rst_block", block, 128'h0);
        chk("t6_rst_valid", block_valid, 1'b0);
        chk("t6_rst_cnt", block_cnt, 32'd0);
        chk("t6_rst_ovr", overrun, 1'b0);
        chk("t6_rst_tmo", timeout_err, 1'b0);
        rst_n = 1'b1;
        block_ready = 1'b1;
        send_block(SEQC, 2, 7);
        repeat (10) step();
        chk("t6_block", block, SEQC);
        chk("t6_cnt", block_cnt, 32'd1);

        // timeout boundary: byte exactly at the limit wins, one cycle later times out
        do_reset();
        for (int i = 0; i < 3; i++) send_byte(8'h70 + 8'(i), 1, TIMEOUT_CYC - 1);
        chk("t7_no_tmo", timeout_err, 1'b0);
        step();
        send_byte(8'h7F, 1, 6);
        chk("t7_tmo", timeout_err, 1'b1);

        // randomized traffic
        do_reset();
        rand_mode = 1'b1;
        for (int n = 0; n < 400; n++) begin
            int hold, gap;
            hold = $urandom_range(1, 4);
            gap  = ($urandom_range(0, 19) == 0) ? $urandom_range(TIMEOUT_CYC - 8, TIMEOUT_CYC + 6)
                                               : $urandom_range(1, 6);
            send_byte(8'($urandom), hold, gap);
        end
        rand_mode = 1'b0;
        block_ready = 1'b1;
        clr_status = 1'b0;
        repeat (40) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
